// File: rtl/f_stage_pkg.sv
// Shared CPU constants: reset/exception vectors, legal instruction-memory
// window and fetch exception codes, also used by CP0 and the M stage.
package f_stage_pkg;

    localparam logic [31:0] RESET_PC_C  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_C = 32'h0000_4180;
    localparam logic [31:0] IM_LO_C     = 32'h0000_3000;
    localparam logic [31:0] IM_HI_C     = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [2:0] {
        NPC_EXC,
        NPC_ERET,
        NPC_HOLD,
        NPC_REDIR,
        NPC_SEQ
    } npc_src_t;

    // Misaligned or outside the inclusive instruction-memory window.
    function automatic logic fetch_fault(input logic [31:0] pc,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/f_stage_npc_sel.sv
// Combinational next-PC priority selector for the fetch stage.
module f_npc_sel
    import f_stage_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_C
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        advance
);

    npc_src_t src;

    // Exceptions and eret win over a stall; a stalled redirect is dropped.
    always_comb begin
        src = NPC_SEQ;
        if (exc_req)
            src = NPC_EXC;
        else if (eret_req)
            src = NPC_ERET;
        else if (stall)
            src = NPC_HOLD;
        else if (redirect_valid)
            src = NPC_REDIR;
    end

    always_comb begin
        npc     = pc + 32'd4;
        advance = 1'b1;
        case (src)
            NPC_EXC:   npc = EXC_ENTRY;
            NPC_ERET:  npc = epc;
            NPC_HOLD: begin
                npc     = pc;
                advance = 1'b0;
            end
            NPC_REDIR: npc = redirect_pc;
            default:   npc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/f_stage.sv
// Fetch stage: PC register, fetch-address fault detection, delay-slot and
// D-flush signalling, and a count of cycles in which the PC advanced.
module f_stage
    import f_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_C,
    parameter logic [31:0] IM_LO     = IM_LO_C,
    parameter logic [31:0] IM_HI     = IM_HI_C
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect_valid,
    input  logic [31:0] Redirect_pc,
    input  logic        Is_branch_D,
    input  logic        Exc_req,
    input  logic        Eret_req,
    input  logic [31:0] Epc,
    output logic [31:0] PC_out,
    output logic [4:0]  Exc_code_out,
    output logic        BD_out,
    output logic        Flush_D,
    output logic [31:0] Fetch_cnt
);

    logic [31:0] pc_q  = RESET_PC;
    logic [31:0] cnt_q = 32'd0;
    logic [31:0] npc;
    logic        advance;

    f_npc_sel #(
        .EXC_ENTRY(EXC_ENTRY)
    ) u_npc_sel (
        .pc            (pc_q),
        .stall         (Stall),
        .redirect_valid(Redirect_valid),
        .redirect_pc   (Redirect_pc),
        .exc_req       (Exc_req),
        .eret_req      (Eret_req),
        .epc           (Epc),
        .npc           (npc),
        .advance       (advance)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= 32'd0;
        end else begin
            pc_q <= npc;
            if (advance)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    // A faulting PC is still presented; the fault travels down the D path.
    assign PC_out       = pc_q;
    assign Exc_code_out = fetch_fault(pc_q, IM_LO, IM_HI) ? EXC_ADEL : EXC_NONE;
    assign Flush_D      = Exc_req | Eret_req;
    assign BD_out       = Is_branch_D & ~(Exc_req | Eret_req);
    assign Fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_f_stage.sv
// Directed bench for f_stage: expected PC/code/count pushed to a scoreboard
// when each step is driven, popped and compared after the clock edge.
module tb_f_stage;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Redirect_valid;
    logic [31:0] Redirect_pc;
    logic        Is_branch_D;
    logic        Exc_req;
    logic        Eret_req;
    logic [31:0] Epc;
    logic [31:0] PC_out;
    logic [4:0]  Exc_code_out;
    logic        BD_out;
    logic        Flush_D;
    logic [31:0] Fetch_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  code;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [31:0] model_cnt;

    f_stage dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Stall         (Stall),
        .Redirect_valid(Redirect_valid),
        .Redirect_pc   (Redirect_pc),
        .Is_branch_D   (Is_branch_D),
        .Exc_req       (Exc_req),
        .Eret_req      (Eret_req),
        .Epc           (Epc),
        .PC_out        (PC_out),
        .Exc_code_out  (Exc_code_out),
        .BD_out        (BD_out),
        .Flush_D       (Flush_D),
        .Fetch_cnt     (Fetch_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs, clock, then
    // compare the registered state against the scoreboard entry.
    task automatic apply_stimulus(input string tag, input logic rst, input logic stall,
                                  input logic redir, input logic [31:0] rpc,
                                  input logic isbr, input logic exc, input logic eret,
                                  input logic [31:0] epc, input logic adv,
                                  input logic [31:0] exp_pc, input logic [4:0] exp_code,
                                  input logic exp_bd, input logic exp_flush);
        exp_t e;
        @(negedge Clk);
        Rst = rst; Stall = stall; Redirect_valid = redir; Redirect_pc = rpc;
        Is_branch_D = isbr; Exc_req = exc; Eret_req = eret; Epc = epc;
        #1;
        check_output({tag, ".bd"}, {31'd0, BD_out}, {31'd0, exp_bd});
        check_output({tag, ".flush"}, {31'd0, Flush_D}, {31'd0, exp_flush});
        if (rst)
            model_cnt = 32'd0;
        else if (adv)
            model_cnt = model_cnt + 32'd1;
        e.pc = exp_pc; e.code = exp_code; e.cnt = model_cnt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check_output({tag, ".pc"}, PC_out, e.pc);
            check_output({tag, ".code"}, {27'd0, Exc_code_out}, {27'd0, e.code});
            check_output({tag, ".cnt"}, Fetch_cnt, e.cnt);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_cnt = 32'd0;
        Rst = 1'b0; Stall = 1'b0; Redirect_valid = 1'b0; Redirect_pc = 32'd0;
        Is_branch_D = 1'b0; Exc_req = 1'b0; Eret_req = 1'b0; Epc = 32'd0;

        //              tag        rst  stl  red  rpc            br   exc  eret epc           adv  pc             code  bd   fl
        apply_stimulus("reset",    1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_3000,5'd0,1'b0,1'b0);
        apply_stimulus("run1",     1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3004,5'd0,1'b0,1'b0);
        apply_stimulus("run2",     1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3008,5'd0,1'b0,1'b0);
        apply_stimulus("run3",     1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_300C,5'd0,1'b0,1'b0);
        apply_stimulus("run4",     1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3010,5'd0,1'b0,1'b0);
        apply_stimulus("stl_redir",1'b0,1'b1,1'b1,32'h0000_3100, 1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0000_3010,5'd0,1'b1,1'b0);
        apply_stimulus("redir",    1'b0,1'b0,1'b1,32'h0000_3100, 1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0000_3100,5'd0,1'b1,1'b0);
        apply_stimulus("redir3020",1'b0,1'b0,1'b1,32'h0000_3020, 1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3020,5'd0,1'b0,1'b0);
        apply_stimulus("stl_exc",  1'b0,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0000_4180,5'd0,1'b0,1'b1);
        apply_stimulus("eret",     1'b0,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,32'h0000_3044,1'b1,32'h0000_3044,5'd0,1'b0,1'b1);
        apply_stimulus("exc_eret", 1'b0,1'b0,1'b1,32'h0000_3200, 1'b0,1'b1,1'b1,32'h0000_3044,1'b1,32'h0000_4180,5'd0,1'b0,1'b1);
        apply_stimulus("mis3102",  1'b0,1'b0,1'b1,32'h0000_3102, 1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3102,5'd4,1'b0,1'b0);
        apply_stimulus("mis3106",  1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3106,5'd4,1'b0,1'b0);
        apply_stimulus("hi7000",   1'b0,1'b0,1'b1,32'h0000_7000, 1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_7000,5'd4,1'b0,1'b0);
        apply_stimulus("edge6FFC", 1'b0,1'b0,1'b1,32'h0000_6FFC, 1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_6FFC,5'd0,1'b0,1'b0);
        apply_stimulus("seq7000",  1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_7000,5'd4,1'b0,1'b0);
        apply_stimulus("lo2FFC",   1'b0,1'b0,1'b1,32'h0000_2FFC, 1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_2FFC,5'd4,1'b0,1'b0);
        apply_stimulus("top",      1'b0,1'b0,1'b1,32'hFFFF_FFFC, 1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,5'd4,1'b0,1'b0);
        apply_stimulus("wrap",     1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0000,5'd4,1'b0,1'b0);
        apply_stimulus("hold",     1'b0,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_0000,5'd4,1'b0,1'b0);
        apply_stimulus("rst_busy", 1'b1,1'b1,1'b1,32'h0000_3100, 1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_3000,5'd0,1'b0,1'b0);
        apply_stimulus("rst_exc",  1'b1,1'b0,1'b0,32'h0,         1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0000_3000,5'd0,1'b0,1'b1);
        apply_stimulus("post_rst", 1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3004,5'd0,1'b0,1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/f_stage.md
F_STAGE -- requirements
Module: f_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter EXC_ENTRY, 32'h0000_4180, exception handler entry address.
REQ-003 Parameters IM_LO 32'h0000_3000 and IM_HI 32'h0000_6FFC, inclusive legal fetch window.
REQ-004 Clk  input  1  single clock; all state updates on posedge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Stall  input  1  hazard-unit hold; PC keeps its value.
REQ-007 Redirect_valid  input  1  D-stage branch taken or jump resolved.
REQ-008 Redirect_pc  input  32  D-stage computed target.
REQ-009 Is_branch_D  input  1  instruction currently in D is a branch/jump.
REQ-010 Exc_req  input  1  CP0 takes an exception or interrupt this cycle.
REQ-011 Eret_req  input  1  eret retiring; return to Epc.
REQ-012 Epc  input  32  CP0 EPC value.
REQ-013 PC_out  output  32  fetch address to IM and to the D pipeline register.
REQ-014 Exc_code_out  output  5  fetch exception code; 0 none, 4 AdEL.
REQ-015 BD_out  output  1  fetched instruction sits in a delay slot.
REQ-016 Flush_D  output  1  clear the D pipeline register this cycle.
REQ-017 Fetch_cnt  output  32  count of cycles in which PC advanced.

Function
REQ-018 PC register SHALL update on posedge Clk with next value by priority: Rst > Exc_req > Eret_req > Stall > Redirect_valid > PC+4.
REQ-019 Exc_req SHALL load EXC_ENTRY regardless of Stall.
REQ-020 Eret_req SHALL load Epc regardless of Stall; no delay slot is executed after eret.
REQ-021 Stall with Redirect_valid SHALL hold PC and drop the redirect; D re-presents it next cycle.
REQ-022 Redirect_valid without stall SHALL load Redirect_pc; the instruction fetched at the cycle of redirect (delay slot) is not squashed.
REQ-023 PC+4 SHALL wrap modulo 2^32 with no flag.
REQ-024 Exc_code_out SHALL be 4 when PC_out[1:0] != 0 or PC_out < IM_LO or PC_out > IM_HI, else 0; combinational from PC register.
REQ-025 On AdEL, PC_out SHALL still be driven unchanged; the D path carries the fault, not F.
REQ-026 BD_out SHALL equal Is_branch_D, forced 0 when Exc_req or Eret_req.
REQ-027 Flush_D SHALL equal Exc_req | Eret_req.
REQ-028 Fetch_cnt SHALL increment by 1 each posedge where PC loads any value other than itself via Exc/Eret/redirect/PC+4 path (i.e. not Rst, not Stall-hold), wrapping at 2^32.
REQ-029 Simultaneous Exc_req and Eret_req SHALL follow Exc_req.

Reset
REQ-030 Rst SHALL set PC to RESET_PC and Fetch_cnt to 0 on the next posedge.
REQ-031 Rst SHALL override every other input, including mid-stall and mid-redirect.
REQ-032 After reset, PC_out=32'h0000_3000, Exc_code_out=0, Fetch_cnt=0.
REQ-033 Registers SHALL carry initial value RESET_PC / 0 for simulation before first reset.

Structure
REQ-034 RESET_PC, EXC_ENTRY, IM_LO, IM_HI and exception code AdEL=4 SHALL live in the shared CPU constants package, also used by CP0 and M stage.
REQ-035 Next-PC priority mux SHALL be one sub-module, f_npc_sel, combinational; PC register and counter stay in f_stage.

Verification
REQ-036 Rst 1 cycle, then free run 3 cycles -> PC_out 3000, 3004, 3008, 300C; Fetch_cnt 3.
REQ-037 PC=3010, Redirect_valid=1, Redirect_pc=3100 -> next PC 3100; with Stall=1 same cycle -> PC stays 3010.
REQ-038 PC=3020, Stall=1, Exc_req=1 -> next PC 4180, Flush_D=1, BD_out=0.
REQ-039 Eret_req=1, Epc=3044 -> next PC 3044; with Exc_req=1 too -> 4180.
REQ-040 Redirect_pc=3102 -> Exc_code_out=4 next cycle; Redirect_pc=7000 -> Exc_code_out=4; 6FFC -> 0.
REQ-041 Rst asserted while Stall=1 and Redirect_valid=1 -> PC 3000, Fetch_cnt 0.
